// File: rtl/ddr_burst_arbiter_if.sv
// ddr_burst_arbiter_if: request/grant and DDR command bundle between the
// frame-buffer channels, the burst arbiter and the DDR controller port.
`default_nettype none

interface ddr_burst_arbiter_if #(
    parameter int NUM_CH = 9,
    parameter int ID_W   = 4
);
    logic [NUM_CH-1:0] wr_req;
    logic [NUM_CH-1:0] rd_req;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ID_W-1:0]   grant_id;
    logic [NUM_CH-1:0] wr_grant;
    logic [NUM_CH-1:0] rd_grant;
    logic              burst_done;
    logic              busy;
    logic              err_timeout;

    // Arbiter side
    modport master (
        input  wr_req,
        input  rd_req,
        input  cmd_ready,
        input  burst_done,
        output cmd_valid,
        output cmd_wr,
        output grant_id,
        output wr_grant,
        output rd_grant,
        output busy,
        output err_timeout
    );

    // Channel / controller side
    modport slave (
        output wr_req,
        output rd_req,
        output cmd_ready,
        output burst_done,
        input  cmd_valid,
        input  cmd_wr,
        input  grant_id,
        input  wr_grant,
        input  rd_grant,
        input  busy,
        input  err_timeout
    );
endinterface

`default_nettype wire

// File: rtl/ddr_burst_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : ddr_burst_arbiter                                              |
// | Brief    : Round-robin burst scheduler sharing one DDR controller port    |
// |            between NUM_CH read/write frame-buffer channels.               |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module ddr_burst_arbiter #(
    parameter int NUM_CH      = 9,
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 4095
) (
    input  wire logic          ddr_clk,
    input  wire logic          sys_rstn,
    ddr_burst_arbiter_if.master bus
);

    localparam int C_TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [C_TCNT_W-1:0] C_TCNT_LAST = C_TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_CH-1:0]   C_ONE       = {{(NUM_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic                r_cmd_valid, w_cmd_valid_nxt;
    logic                r_cmd_wr,    w_cmd_wr_nxt;
    logic [ID_W-1:0]     r_grant_id,  w_grant_id_nxt;
    logic [NUM_CH-1:0]   r_wr_grant,  w_wr_grant_nxt;
    logic [NUM_CH-1:0]   r_rd_grant,  w_rd_grant_nxt;
    logic                r_err,       w_err_nxt;
    logic [ID_W-1:0]     r_wr_ptr,    w_wr_ptr_nxt;
    logic [ID_W-1:0]     r_rd_ptr,    w_rd_ptr_nxt;
    logic                r_last_wr,   w_last_wr_nxt;
    logic [C_TCNT_W-1:0] r_tcnt,      w_tcnt_nxt;

    logic                w_any_wr;
    logic                w_any_rd;
    logic                w_sel_wr;
    logic [ID_W-1:0]     w_wr_pick;
    logic [ID_W-1:0]     w_rd_pick;
    logic [ID_W-1:0]     w_pick;
    logic [ID_W-1:0]     w_pick_inc;
    logic [NUM_CH-1:0]   w_pick_onehot;

    // First requester at or after ptr, wrapping past NUM_CH-1 back to 0
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [ID_W-1:0]   ptr);
        logic            found;
        logic [ID_W-1:0] pick;
        int              idx;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    assign w_any_wr      = |bus.wr_req;
    assign w_any_rd      = |bus.rd_req;
    // Both types pending: alternate against the type granted last time
    assign w_sel_wr      = w_any_wr && (!w_any_rd || !r_last_wr);
    assign w_wr_pick     = rr_pick(bus.wr_req, r_wr_ptr);
    assign w_rd_pick     = rr_pick(bus.rd_req, r_rd_ptr);
    assign w_pick        = w_sel_wr ? w_wr_pick : w_rd_pick;
    assign w_pick_inc    = (w_pick == ID_W'(NUM_CH - 1)) ? '0 : w_pick + 1'b1;
    assign w_pick_onehot = C_ONE << w_pick;

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_wr_nxt    = r_cmd_wr;
        w_grant_id_nxt  = r_grant_id;
        w_wr_grant_nxt  = r_wr_grant;
        w_rd_grant_nxt  = r_rd_grant;
        w_err_nxt       = 1'b0;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_last_wr_nxt   = r_last_wr;
        w_tcnt_nxt      = r_tcnt;

        case (r_state)
            S_IDLE: begin
                if (w_any_wr || w_any_rd) begin
                    w_state_nxt     = S_CMD;
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_wr_nxt    = w_sel_wr;
                    w_grant_id_nxt  = w_pick;
                    w_last_wr_nxt   = w_sel_wr;
                    if (w_sel_wr) begin
                        w_wr_grant_nxt = w_pick_onehot;
                        w_wr_ptr_nxt   = w_pick_inc;
                    end else begin
                        w_rd_grant_nxt = w_pick_onehot;
                        w_rd_ptr_nxt   = w_pick_inc;
                    end
                end
            end

            S_CMD: begin
                if (bus.cmd_ready) begin
                    w_state_nxt     = S_DATA;
                    w_cmd_valid_nxt = 1'b0;
                    w_tcnt_nxt      = '0;
                end
            end

            S_DATA: begin
                if (bus.burst_done || (r_tcnt == C_TCNT_LAST)) begin
                    // Pointer already moved at grant, so a hung channel loses its turn
                    w_err_nxt      = !bus.burst_done;
                    w_state_nxt    = S_IDLE;
                    w_cmd_wr_nxt   = 1'b0;
                    w_grant_id_nxt = '0;
                    w_wr_grant_nxt = '0;
                    w_rd_grant_nxt = '0;
                    w_tcnt_nxt     = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_cmd_valid_nxt = 1'b0;
                w_cmd_wr_nxt    = 1'b0;
                w_grant_id_nxt  = '0;
                w_wr_grant_nxt  = '0;
                w_rd_grant_nxt  = '0;
                w_tcnt_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge ddr_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_wr    <= 1'b0;
            r_grant_id  <= '0;
            r_wr_grant  <= '0;
            r_rd_grant  <= '0;
            r_err       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_wr   <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_wr    <= w_cmd_wr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_wr_grant  <= w_wr_grant_nxt;
            r_rd_grant  <= w_rd_grant_nxt;
            r_err       <= w_err_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_last_wr   <= w_last_wr_nxt;
            r_tcnt      <= w_tcnt_nxt;
        end
    end

    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_wr      = r_cmd_wr;
    assign bus.grant_id    = r_grant_id;
    assign bus.wr_grant    = r_wr_grant;
    assign bus.rd_grant    = r_rd_grant;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.err_timeout = r_err;

endmodule

`default_nettype wire
